// File: rtl/capture_byte_serializer.sv
// ============================================================================
// Module   : capture_byte_serializer
// Summary  : Drains one capture from the first-stage FIFO and emits its words
//            MSB-first as a valid/ready byte stream. Optional CAPTURE_HEADER_EN
//            prefixes each capture with 0xA5, 0x5A and the word count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_byte_serializer #(
  parameter int WORDS_PER_CAPTURE = 128,
  parameter int VALID_TIMEOUT     = 16,
  parameter int CNT_W             = 8
) (
  input  logic        SysClk,
  input  logic        ResetN,
  input  logic [31:0] DataIn,
  input  logic        DataValid,
  input  logic        DataReady,
  output logic        RdEn,
  output logic [7:0]  ByteOut,
  output logic        ByteValid,
  input  logic        ByteReady,
  output logic        Busy,
  output logic        CaptureDone,
  output logic        TimeoutErr
);

  localparam int              TO_W           = $clog2(VALID_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_WORDS       = CNT_W'(WORDS_PER_CAPTURE);
  localparam logic [TO_W-1:0]  C_TIMEOUT_LAST = TO_W'(VALID_TIMEOUT - 1);

`ifdef CAPTURE_HEADER_EN
  localparam logic [7:0] C_HDR_LEN = 8'(WORDS_PER_CAPTURE);

  typedef enum logic [5:0] {
    S_IDLE         = 6'b000001,
    S_HEADER       = 6'b000010,
    S_READ         = 6'b000100,
    S_WAIT_VALID   = 6'b001000,
    S_SEND         = 6'b010000,
    S_WAIT_RELEASE = 6'b100000
  } state_t;
`else
  typedef enum logic [4:0] {
    S_IDLE         = 5'b00001,
    S_READ         = 5'b00010,
    S_WAIT_VALID   = 5'b00100,
    S_SEND         = 5'b01000,
    S_WAIT_RELEASE = 5'b10000
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [31:0]      word_q, word_d;
  logic             done_q, done_d;

  logic             rden_w;
  logic             bvalid_w;
  logic [7:0]       bsel_w;
  logic             timeout_w;
  logic [CNT_W-1:0] wcnt_inc_w;

  assign wcnt_inc_w = wcnt_q + 1'b1;

  always_ff @(posedge SysClk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      bidx_q  <= '0;
      tcnt_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bidx_q  <= bidx_d;
      tcnt_q  <= tcnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bidx_d    = bidx_q;
    tcnt_d    = tcnt_q;
    word_d    = word_q;
    done_d    = 1'b0;
    rden_w    = 1'b0;
    bvalid_w  = 1'b0;
    bsel_w    = 8'h00;
    timeout_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (DataReady) begin
          bidx_d  = 2'd0;
`ifdef CAPTURE_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_READ;
`endif
        end
      end

`ifdef CAPTURE_HEADER_EN
      S_HEADER: begin
        bvalid_w = 1'b1;
        case (bidx_q)
          2'd0:    bsel_w = 8'hA5;
          2'd1:    bsel_w = 8'h5A;
          default: bsel_w = C_HDR_LEN;
        endcase
        if (ByteReady) begin
          if (bidx_q == 2'd2) begin
            bidx_d  = 2'd0;
            state_d = S_READ;
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
`endif

      S_READ: begin
        rden_w  = 1'b1;
        tcnt_d  = '0;
        state_d = S_WAIT_VALID;
      end

      S_WAIT_VALID: begin
        if (DataValid) begin
          word_d  = DataIn;
          bidx_d  = 2'd0;
          state_d = S_SEND;
        end else if (tcnt_q == C_TIMEOUT_LAST) begin
          // Capture abandoned; still wait for the upstream flag to drop.
          timeout_w = 1'b1;
          tcnt_d    = tcnt_q + 1'b1;
          state_d   = S_WAIT_RELEASE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      S_SEND: begin
        bvalid_w = 1'b1;
        case (bidx_q)
          2'd0:    bsel_w = word_q[31:24];
          2'd1:    bsel_w = word_q[23:16];
          2'd2:    bsel_w = word_q[15:8];
          default: bsel_w = word_q[7:0];
        endcase
        if (ByteReady) begin
          if (bidx_q == 2'd3) begin
            bidx_d = 2'd0;
            wcnt_d = wcnt_inc_w;
            if (wcnt_inc_w == C_WORDS) begin
              done_d  = 1'b1;
              state_d = S_WAIT_RELEASE;
            end else begin
              state_d = S_READ;
            end
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end

      S_WAIT_RELEASE: begin
        if (!DataReady) begin
          wcnt_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign RdEn        = rden_w;
  assign ByteValid   = bvalid_w;
  assign ByteOut     = bsel_w;
  assign Busy        = (state_q != S_IDLE);
  assign CaptureDone = done_q;
  assign TimeoutErr  = timeout_w;

endmodule

`default_nettype wire

// File: doc/capture_byte_serializer.md
Name: capture_byte_serializer

Overview:
- Downstream consumer of the first-stage dual-clock capture FIFOs.
- Runs on SysClk. Once a capture is flagged ready, it drains exactly WORDS_PER_CAPTURE 32-bit words by pulsing the FIFO read enable.
- Each word is split into 4 bytes and presented on a valid/ready byte stream toward the host-interface transmitter.
- It then waits for the upstream ready flag to drop, so one trigger produces exactly one capture.

Parameters:
- WORDS_PER_CAPTURE, 128: words drained per capture (first-stage FIFO depth).
- VALID_TIMEOUT, 16: SysClk cycles allowed between RdEn pulse and DataValid before abort.
- CNT_W, 8: width of the word counter; must hold WORDS_PER_CAPTURE.

Ports:
- SysClk  in  1  system clock, ~100 MHz
- ResetN  in  1  asynchronous active-low reset
- DataIn  in  32  FIFO read data; byte lanes [31:24],[23:16],[15:8],[7:0]
- DataValid  in  1  read data valid, 1 cycle after RdEn
- DataReady  in  1  capture-complete level, already synchronized to SysClk
- RdEn  out  1  single-cycle FIFO read strobe
- ByteOut  out  8  serialized byte
- ByteValid  out  1  ByteOut valid
- ByteReady  in  1  downstream accepts byte
- Busy  out  1  high in any state except IDLE
- CaptureDone  out  1  one-cycle pulse after last byte accepted
- TimeoutErr  out  1  one-cycle pulse on DataValid timeout

Behaviour:
- Reset (ResetN low, asynchronous):
  - state=IDLE; word count, byte index and timeout count cleared; word register=0.
  - All outputs 0.
- Transfer rule: a byte transfers on a rising SysClk edge where ByteValid & ByteReady.
  - While ByteValid=1 and ByteReady=0, ByteOut and ByteValid hold stable.
- States, one-hot:
  - IDLE: if DataReady=1, go to READ.
  - READ: RdEn=1 for exactly this cycle; clear timeout count; go to WAIT_VALID.
  - WAIT_VALID:
    - If DataValid=1: latch DataIn into word register, byte index=0, go to SEND.
    - Otherwise increment timeout count. When it reaches VALID_TIMEOUT: pulse TimeoutErr, go to WAIT_RELEASE (capture abandoned).
  - SEND:
    - ByteValid=1. ByteOut selected by byte index: 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
    - On a transfer with index<3: index+1.
    - On a transfer with index=3: word count+1. If new count=WORDS_PER_CAPTURE, pulse CaptureDone and go to WAIT_RELEASE; else go to READ.
  - WAIT_RELEASE: hold until DataReady=0, then clear word count and go to IDLE.
- Latency:
  - DataReady rising to RdEn: 1 cycle.
  - DataValid to first ByteValid: 1 cycle.
  - Minimum cycles per word with ByteReady tied high: 6 (READ, WAIT_VALID, 4×SEND).
- At most one RdEn per word. RdEn is never asserted outside READ, so the upstream FIFO cannot be over-read.
- DataValid seen outside WAIT_VALID is ignored.
- DataReady dropping mid-capture is ignored; the capture completes the full word count. Upstream only clears it once empty.
- DataReady still high in WAIT_RELEASE: no new capture starts until it falls low and rises again.
- ResetN asserted mid-capture: immediate return to IDLE; a partially sent word is discarded with no CaptureDone.
- Word counter compares for equality and never wraps within a capture.

Optional Feature:
- Macro CAPTURE_HEADER_EN.
- Defined:
  - IDLE moves to HEADER instead of READ.
  - HEADER emits 0xA5, 0x5A, then WORDS_PER_CAPTURE[7:0], using the same handshake, then goes to READ.
  - A timeout after the header still ends in WAIT_RELEASE.
  - Adds 3 byte slots per capture.
- Not defined: no HEADER state; the byte stream is data only.

Test Plan:
- WORDS_PER_CAPTURE=4, ByteReady=1, DataReady raised, model returns 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 one cycle after each RdEn:
  - Expect 16 bytes 0x11,0x22,…,0x00 in order.
  - Exactly 4 RdEn pulses.
  - CaptureDone pulses once.
- ByteReady toggled as pseudo-random 50% pattern:
  - ByteOut/ByteValid stable while stalled.
  - No byte lost or duplicated.
  - RdEn never asserted during SEND.
- DataValid withheld after the 2nd RdEn:
  - TimeoutErr pulses exactly VALID_TIMEOUT cycles later.
  - No CaptureDone.
  - Block idles once DataReady=0.
- DataReady held high after CaptureDone:
  - No further RdEn.
  - After DataReady low for 1 cycle then high, a new capture starts with RdEn 1 cycle later.
- ResetN pulsed low during byte index 2 of word 3: all outputs 0 asynchronously; next DataReady starts from word 0.
- CAPTURE_HEADER_EN defined, WORDS_PER_CAPTURE=4: first bytes 0xA5,0x5A,0x04, then the 16 data bytes.
